// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ RAM responder slice.
// Holds responder state encoding, default widths and bus strobe polarity.
package subleq_pkg;

    localparam int ADR_W_DEF = 8;
    localparam int DAT_W_DEF = 8;

    localparam logic RAM_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/subleq_ram_array.sv
// Single-port synchronous RAM with write-first read data.
// Only the read register is reset; stored contents survive reset.
module subleq_ram_array #(
    parameter int ADR_W = 8,
    parameter int DAT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             we,
    input  logic             re,
    input  logic [ADR_W-1:0] addr,
    input  logic [DAT_W-1:0] wdata,
    output logic [DAT_W-1:0] rdata
);

    logic [DAT_W-1:0] mem [2**ADR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/subleq_ram_responder.sv
// RAM-bus responder for the SUBLEQ core with a host byte-stream loader.
// Loader fills memory from address 0, then RUN releases the core.
module subleq_ram_responder
    import subleq_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int DAT_W = DAT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic [ADR_W-1:0] adr,
    input  logic [DAT_W-1:0] dat_in,
    output logic [DAT_W-1:0] dat_out,
    output logic             dat_oe,
    input  logic             ram_ena,
    input  logic             ram_ope,
    input  logic             ram_ctl,
    input  logic             ld_start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [DAT_W-1:0] ld_data,
    input  logic             ld_last,
    output logic             cpu_run,
    output logic [ADR_W-1:0] wr_count
);

    state_t state, state_n;

    logic [ADR_W-1:0] ptr;
    logic             ctl_q;
    logic             accept;
    logic             ptr_max;
    logic             rd_fire;
    logic             wr_fire;
    logic             mem_we;
    logic             mem_re;
    logic [ADR_W-1:0] mem_addr;
    logic [DAT_W-1:0] mem_wdata;

    // ld_start always wins: it drops loader bytes and in-flight core strobes
    always_comb begin
        accept  = (state == LOAD) && ld_valid && ld_ready && !ld_start;
        ptr_max = (ptr == '1);
        rd_fire = (state == RUN) && !ld_start
                  && (ram_ena == RAM_ACTIVE)
                  && (ram_ope == RAM_ACTIVE);
        wr_fire = (state == RUN) && !ld_start
                  && (ram_ena == RAM_ACTIVE)
                  && (ram_ope != RAM_ACTIVE)
                  && (ram_ctl == RAM_ACTIVE)
                  && (ctl_q != RAM_ACTIVE);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (ld_start) state_n = LOAD;
            LOAD: if (accept && (ld_last || ptr_max)) state_n = RUN;
            RUN:  if (ld_start) state_n = LOAD;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = !res && (accept || wr_fire);
        mem_re    = !res && rd_fire;
        mem_addr  = (state == LOAD) ? ptr : adr;
        mem_wdata = (state == LOAD) ? ld_data : dat_in;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            dat_oe   <= 1'b0;
            ld_ready <= 1'b0;
            cpu_run  <= 1'b0;
            wr_count <= '0;
            ptr      <= '0;
            ctl_q    <= !RAM_ACTIVE;
        end else begin
            state    <= state_n;
            ctl_q    <= ram_ctl;
            dat_oe   <= rd_fire;
            ld_ready <= (state == LOAD) && (state_n == LOAD);
            cpu_run  <= (state == RUN) && (state_n == RUN);
            if (ld_start) begin
                ptr      <= '0;
                wr_count <= '0;
            end else if (accept) begin
                if (!ptr_max) ptr <= ptr + ADR_W'(1);
                if (wr_count != '1) wr_count <= wr_count + ADR_W'(1);
            end
        end
    end

    subleq_ram_array #(
        .ADR_W(ADR_W),
        .DAT_W(DAT_W)
    ) u_array (
        .clk  (clk),
        .res  (res),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(dat_out)
    );

endmodule

// File: tb/tb_subleq_ram_responder.sv
// Self-checking bench for subleq_ram_responder: directed table, corner
// sequences and random bus traffic against an array reference model.
module tb_subleq_ram_responder;

    logic       clk = 1'b0;
    logic       res;
    logic [7:0] adr;
    logic [7:0] dat_in;
    logic [7:0] dat_out;
    logic       dat_oe;
    logic       ram_ena;
    logic       ram_ope;
    logic       ram_ctl;
    logic       ld_start;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       cpu_run;
    logic [7:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [256];
    bit         known   [256];
    logic [7:0] ldq     [$];

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        int         hold;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    subleq_ram_responder dut (
        .clk     (clk),
        .res     (res),
        .adr     (adr),
        .dat_in  (dat_in),
        .dat_out (dat_out),
        .dat_oe  (dat_oe),
        .ram_ena (ram_ena),
        .ram_ope (ram_ope),
        .ram_ctl (ram_ctl),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .cpu_run (cpu_run),
        .wr_count(wr_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        ram_ena = 1'b1;
        ram_ope = 1'b1;
        ram_ctl = 1'b1;
    endtask

    // every task starts and ends just after a negedge
    task automatic bus_read(input logic [7:0] a, input string nm);
        adr     = a;
        ram_ena = 1'b0;
        ram_ope = 1'b0;
        ram_ctl = 1'b1;
        @(negedge clk);
        bus_idle();
        chk({nm, "_oe"}, dat_oe, 1);
        if (known[a]) chk(nm, dat_out, ref_mem[a]);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] d2, input int hold);
        adr     = a;
        dat_in  = d;
        ram_ena = 1'b0;
        ram_ope = 1'b1;
        ram_ctl = 1'b0;
        @(negedge clk);
        dat_in = d2;
        repeat (hold - 1) @(negedge clk);
        bus_idle();
        @(negedge clk);
        ref_mem[a] = d;
        known[a]   = 1'b1;
    endtask

    task automatic send_byte(input int idx, input logic [7:0] d,
                             input bit last, input string nm);
        int budget;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        budget   = 0;
        while (!ld_ready && budget < 8) begin
            @(negedge clk);
            budget++;
        end
        if (!ld_ready) begin
            chk({nm, "_rdy_timeout"}, ld_ready, 1);
        end else begin
            @(negedge clk);
            ref_mem[idx] = d;
            known[idx]   = 1'b1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load(input bit use_last, input string nm);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        foreach (ldq[i]) begin
            send_byte(i, ldq[i], use_last && (i == ldq.size() - 1), nm);
        end
        chk({nm, "_run_lag"}, cpu_run, 0);
        chk({nm, "_rdy_drop"}, ld_ready, 0);
        @(negedge clk);
        chk({nm, "_run_up"}, cpu_run, 1);
        chk({nm, "_count"}, wr_count,
            (ldq.size() > 255) ? 255 : ldq.size());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h40, 8'h3C, 1, 8'h00};
        vecs[1]  = '{1'b0, 8'h40, 8'h00, 1, 8'h3C};
        vecs[2]  = '{1'b1, 8'h40, 8'h99, 2, 8'h00};
        vecs[3]  = '{1'b0, 8'h40, 8'h00, 1, 8'h99};
        vecs[4]  = '{1'b1, 8'hFF, 8'h80, 1, 8'h00};
        vecs[5]  = '{1'b0, 8'hFF, 8'h00, 1, 8'h80};
        vecs[6]  = '{1'b1, 8'h00, 8'hEE, 3, 8'h00};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 1, 8'hEE};
        vecs[8]  = '{1'b0, 8'h02, 8'h00, 1, 8'h10};
        vecs[9]  = '{1'b1, 8'h30, 8'h5A, 1, 8'h00};
        vecs[10] = '{1'b0, 8'h30, 8'h00, 1, 8'h5A};
        vecs[11] = '{1'b1, 8'h41, 8'h12, 1, 8'h00};

        res      = 1'b1;
        adr      = '0;
        dat_in   = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        res = 1'b0;
        chk("rst_dat_out", dat_out, 0);
        chk("rst_dat_oe", dat_oe, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_wr_count", wr_count, 0);

        ldq = '{8'h05, 8'h06, 8'h10};
        load(1'b1, "load3");
        bus_read(8'h00, "rd0");
        bus_read(8'h01, "rd1");
        chk("rd1_val", dat_out, 8'h06);
        @(negedge clk);
        chk("idle_oe", dat_oe, 0);
        chk("idle_hold", dat_out, 8'h06);
        bus_read(8'h02, "rd2");

        bus_write(8'h20, 8'hFB, 8'h11, 3);
        bus_read(8'h20, "held_strobe");
        chk("held_val", dat_out, 8'hFB);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].a, vecs[i].d, ~vecs[i].d, vecs[i].hold);
            end else begin
                bus_read(vecs[i].a, $sformatf("vec%0d", i));
                chk($sformatf("vec%0d_exp", i), dat_out, vecs[i].exp);
            end
        end

        // read with ram_ctl low must not write
        adr     = 8'h41;
        dat_in  = 8'h44;
        ram_ena = 1'b0;
        ram_ope = 1'b0;
        ram_ctl = 1'b0;
        @(negedge clk);
        bus_idle();
        chk("rd_ctl_low", dat_out, 8'h12);
        @(negedge clk);
        bus_read(8'h41, "rd_ctl_low_again");

        // write then read same address on the very next cycle
        adr     = 8'h55;
        dat_in  = 8'h3E;
        ram_ena = 1'b0;
        ram_ope = 1'b1;
        ram_ctl = 1'b0;
        @(negedge clk);
        ram_ope = 1'b0;
        ram_ctl = 1'b1;
        @(negedge clk);
        bus_idle();
        chk("raw_val", dat_out, 8'h3E);
        ref_mem[8'h55] = 8'h3E;
        known[8'h55]   = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 250; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            bit         w;
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            w = ($urandom_range(0, 1) == 1) || !known[a];
            if (w) bus_write(a, d, 8'($urandom), $urandom_range(1, 3));
            else bus_read(a, $sformatf("rnd%0d", i));
        end

        // ld_start in RUN on the falling strobe cycle
        ld_start = 1'b1;
        adr      = 8'h30;
        dat_in   = 8'hAA;
        ram_ena  = 1'b0;
        ram_ope  = 1'b1;
        ram_ctl  = 1'b0;
        @(negedge clk);
        ld_start = 1'b0;
        chk("abort_run_drop", cpu_run, 0);
        @(negedge clk);
        bus_idle();
        ldq = '{8'h77};
        load(1'b1, "reload");
        bus_read(8'h30, "abort_no_write");
        bus_read(8'h00, "reload_rd0");
        chk("reload_val", dat_out, 8'h77);

        ldq.delete();
        for (int i = 0; i < 256; i++) ldq.push_back(8'(i));
        load(1'b0, "full");
        bus_read(8'hFF, "full_rdff");
        chk("full_ff", dat_out, 8'hFF);
        bus_read(8'h80, "full_rd80");

        // reset in the middle of a load
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        send_byte(0, 8'hC1, 1'b0, "mid0");
        send_byte(1, 8'hC2, 1'b0, "mid1");
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk("midrst_run", cpu_run, 0);
        chk("midrst_count", wr_count, 0);
        chk("midrst_ready", ld_ready, 0);
        chk("midrst_oe", dat_oe, 0);
        ldq = '{8'hC1};
        load(1'b1, "post_rst");
        bus_read(8'h00, "retain0");
        bus_read(8'h01, "retain1");
        chk("retain1_val", dat_out, 8'hC2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/subleq_ram_responder.md
Name: subleq_ram_responder

Overview:
- Memory-side responder for the SUBLEQ machine's RAM bus. Services the control unit's address/data/strobe protocol (ram_ena, ram_ope, ram_ctl) against an internal synchronous 256x8 array.
- Includes a host loader. A byte-stream handshake fills program memory before the core runs, and cpu_run gates the core's operation.
- Sits between the control unit/register datapath and the host or testbench.

Parameters:
ADR_W, 8, address width; array depth = 2**ADR_W
DAT_W, 8, data width

Ports:
clk  input  1  system clock
res  input  1  reset, synchronous, active-high
adr  input  ADR_W  RAM address from the selected address register
dat_in  input  DAT_W  write data from the core (valid when the core drives the bus, dat_dir=0 side)
dat_out  output  DAT_W  read data to the core
dat_oe  output  1  high when dat_out is valid and driven
ram_ena  input  1  chip enable, active-low
ram_ope  input  1  output enable, active-low (0 = read cycle)
ram_ctl  input  1  write strobe, active-low
ld_start  input  1  pulse: begin program load at address 0
ld_valid  input  1  host byte valid
ld_ready  output  1  responder accepts a host byte
ld_data  input  DAT_W  host byte
ld_last  input  1  marks the final host byte (qualified by ld_valid&&ld_ready)
cpu_run  output  1  high in RUN; releases the core
wr_count  output  ADR_W  number of bytes loaded, saturating at 2**ADR_W-1

Behaviour:
- Reset (res=1 at a posedge clk):
  - state=IDLE, dat_out=0, dat_oe=0, ld_ready=0, cpu_run=0, wr_count=0, load pointer=0, ctl_q=1.
  - Array contents are not cleared.
  - A reset mid-LOAD or mid-RUN aborts immediately. Bytes already written stay in the array.
- State machine:
  - IDLE: ld_ready=0, cpu_run=0, bus ignored. ld_start -> LOAD with pointer=0 and wr_count=0.
  - LOAD: ld_ready=1 (registered, asserted the cycle after entry). On ld_valid&&ld_ready: mem[pointer]<=ld_data, pointer++, wr_count++.
    - If ld_last, or pointer==2**ADR_W-1 at acceptance, go to RUN next cycle.
    - Pointer wrap is impossible because the transition happens first.
    - ld_start during LOAD restarts: pointer=0, wr_count=0, and any byte presented that cycle is dropped.
  - RUN: cpu_run=1, ld_ready=0, bus serviced. ld_start -> LOAD: cpu_run drops the next cycle, bus servicing stops, and any in-flight strobe is ignored.
- Read (RUN only):
  - When ram_ena=0 and ram_ope=0 at a posedge, the next cycle has dat_out=mem[adr] and dat_oe=1. Latency is 1 clk.
  - Otherwise dat_oe=0 and dat_out holds its last value.
- Write (RUN only):
  - ctl_q registers ram_ctl each cycle.
  - A write occurs on a falling strobe: ram_ena=0 && ram_ope=1 && ram_ctl=0 && ctl_q=1, giving mem[adr]<=dat_in.
  - Holding ram_ctl low for N cycles writes exactly once.
  - ram_ope=0 with ram_ctl=0 is treated as a read only; no write occurs.
- Read-after-write to the same address in consecutive cycles returns the new data (array write-first ordering).
- Widths: wr_count saturates and does not wrap. The pointer is ADR_W bits.
- Simultaneous ld_start and ld_valid in IDLE: ld_ready=0, so no byte is accepted.

Decomposition:
- Shared package subleq_pkg: state encoding (IDLE=0, LOAD=1, RUN=2), ADR_W/DAT_W defaults, and strobe polarity constants (RAM_ACTIVE=0).
- One sub-module: subleq_ram_array, a single-port synchronous 2**ADR_W x DAT_W array with write-first behaviour. The responder muxes the loader and core ports into it.
- FSM, strobe edge detect and counters stay in the top level.

Test Plan:
- Reset then load: ld_start, then bytes 0x05,0x06,0x10 with ld_last on 0x10 -> mem[0..2]=05,06,10; wr_count=3; cpu_run=1 two cycles after the last accept.
- Read: in RUN, adr=0x01, ram_ena=0, ram_ope=0 for one cycle -> next cycle dat_out=0x06, dat_oe=1; the following idle cycle gives dat_oe=0.
- Write strobe held: adr=0x20, dat_in=0xFB, ram_ope=1, ram_ctl low for 3 cycles with dat_in changing to 0x11 on the 2nd cycle -> mem[0x20]=0xFB (single write); a readback returns 0xFB.
- Full load: 256 bytes (value=address), no ld_last -> RUN entered after byte 255; wr_count=0xFF; mem[0xFF]=0xFF.
- ld_start in RUN mid-write strobe -> no write occurs; cpu_run=0 next cycle; a new load at 0 overwrites mem[0].
- res asserted mid-LOAD after 2 bytes -> IDLE, cpu_run=0, wr_count=0; mem[0..1] retain the loaded values and are verified after a fresh load with ld_last on byte 0.
